alu_exec_unit: RTL and testbench

Parametrised, multi-cycle successor to the combinational ALU-control decoder: decodes `alu_operation`/`function_code` and executes the selected operation in one block.
- Single-cycle ops: add, sub, and, or, slt, sll, srl, mfhi, mflo.
- Iterative ops: MULT/MULTU, plus optional DIV/DIVU, writing architectural HI/LO registers.
- Sits in the EX stage between register read and writeback, with valid/ready handshakes on both sides so the pipeline stalls during multi-cycle ops.

---
 rtl/alu_pkg.sv | 108 ++++++++++
 rtl/alu_exec_unit_muldiv.sv | 137 +++++++++++++
 rtl/alu_exec_unit.sv | 170 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the EX-stage ALU execution unit: operation
// enum, R-format funct codes, main-control op-class codes, FSM state type and
// the op/funct decoder used by the top.
// Configuration macro: ALU_DIV_EN (adds DIV/DIVU decode and the DIV state).
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_SLT   = 4'd4,
      OP_SLL   = 4'd5,
      OP_SRL   = 4'd6,
      OP_MFHI  = 4'd7,
      OP_MFLO  = 4'd8,
      OP_MULT  = 4'd9,
      OP_MULTU = 4'd10,
      OP_DIV   = 4'd11,
      OP_DIVU  = 4'd12
   } alu_op_t;

   // R-format funct field values
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   // Main-control op-class values
   localparam logic [2:0] AOP_ADD   = 3'b000;
   localparam logic [2:0] AOP_SUB   = 3'b001;
   localparam logic [2:0] AOP_RTYPE = 3'b010;
   localparam logic [2:0] AOP_RSV0  = 3'b011;
   localparam logic [2:0] AOP_ADDI  = 3'b100;
   localparam logic [2:0] AOP_AND   = 3'b101;
   localparam logic [2:0] AOP_RSV1  = 3'b110;
   localparam logic [2:0] AOP_OR    = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
`ifdef ALU_DIV_EN
      ST_DIV  = 2'd2,
`endif
      ST_DONE = 2'd3
   } fsm_state_t;

   typedef struct packed {
      alu_op_t op;
      logic    illegal;
   } alu_dec_t;

   // Undecodable encodings fall back to add with the illegal flag raised.
   function automatic alu_dec_t alu_decode(input logic [2:0] alu_operation,
                                           input logic [5:0] function_code);
      alu_dec_t d;
      d.op      = OP_ADD;
      d.illegal = 1'b0;
      case (alu_operation)
         AOP_ADD, AOP_ADDI: d.op = OP_ADD;
         AOP_SUB:           d.op = OP_SUB;
         AOP_AND:           d.op = OP_AND;
         AOP_OR:            d.op = OP_OR;
         AOP_RTYPE: begin
            case (function_code)
               FN_ADD:   d.op = OP_ADD;
               FN_SUB:   d.op = OP_SUB;
               FN_AND:   d.op = OP_AND;
               FN_OR:    d.op = OP_OR;
               FN_SLT:   d.op = OP_SLT;
               FN_SLL:   d.op = OP_SLL;
               FN_SRL:   d.op = OP_SRL;
               FN_MFHI:  d.op = OP_MFHI;
               FN_MFLO:  d.op = OP_MFLO;
               FN_MULT:  d.op = OP_MULT;
               FN_MULTU: d.op = OP_MULTU;
`ifdef ALU_DIV_EN
               FN_DIV:   d.op = OP_DIV;
               FN_DIVU:  d.op = OP_DIVU;
`endif
               default: begin
                  d.op      = OP_ADD;
                  d.illegal = 1'b1;
               end
            endcase
         end
         default: begin
            // 011 and 110 are reserved classes
            d.op      = OP_ADD;
            d.illegal = 1'b1;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_exec_unit_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv_iter
// Iterative datapath: shift-add multiplier (one multiplier bit per cycle) and,
// with ALU_DIV_EN, a restoring divider (one quotient bit per cycle). Works on
// operand magnitudes; sign correction is applied combinationally on the final
// iteration so hi_res/lo_res are already architectural values when done=1.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   start            load operands and begin DATA_W iterations
//   is_signed        treat a/b as two's complement
//   div              (ALU_DIV_EN) divide instead of multiply
//   a, b             operands (multiplicand/multiplier or dividend/divisor)
//   done             final iteration in progress; hi_res/lo_res valid
//   hi_res, lo_res   product halves, or remainder/quotient
//   dbz              (ALU_DIV_EN) divide by zero for the current operation
// -----------------------------------------------------------------------------
module alu_muldiv_iter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              is_signed,
`ifdef ALU_DIV_EN
   input  logic              div,
   output logic              dbz,
`endif
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] hi_res,
   output logic [DATA_W-1:0] lo_res
);

   localparam int CNT_W = $clog2(DATA_W);

   logic              busy_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [DATA_W-1:0] acc_r;     // upper product word / partial remainder
   logic [DATA_W-1:0] q_r;       // multiplier / dividend shifting to quotient
   logic [DATA_W-1:0] m_r;       // multiplicand / divisor magnitude
   logic              neg_q_r;   // negate product or quotient at the end

   logic                a_neg_s;
   logic                b_neg_s;
   logic [DATA_W:0]     sum_s;
   logic [DATA_W-1:0]   mul_acc_s;
   logic [DATA_W-1:0]   mul_q_s;
   logic [2*DATA_W-1:0] prod_fix_s;
   logic [DATA_W-1:0]   acc_nx_s;
   logic [DATA_W-1:0]   q_nx_s;

`ifdef ALU_DIV_EN
   logic              div_r;
   logic              dbz_r;
   logic              neg_r_r;   // remainder takes the dividend's sign
   logic [DATA_W:0]   sh_s;
   logic              ge_s;
   logic [DATA_W-1:0] diff_s;
   logic [DATA_W-1:0] div_acc_s;
   logic [DATA_W-1:0] div_q_s;
   logic [DATA_W-1:0] quo_s;
   logic [DATA_W-1:0] rem_s;

   assign dbz = dbz_r;
`endif

   assign a_neg_s = is_signed & a[DATA_W-1];
   assign b_neg_s = is_signed & b[DATA_W-1];
   assign done    = busy_r && (cnt_r == {CNT_W{1'b0}});

   // One iteration step plus final sign correction of the results
   always_comb begin
      sum_s      = {1'b0, acc_r} + (q_r[0] ? {1'b0, m_r} : {(DATA_W+1){1'b0}});
      mul_acc_s  = sum_s[DATA_W:1];
      mul_q_s    = {sum_s[0], q_r[DATA_W-1:1]};
      prod_fix_s = neg_q_r ? -{mul_acc_s, mul_q_s} : {mul_acc_s, mul_q_s};
`ifdef ALU_DIV_EN
      sh_s      = {acc_r, q_r[DATA_W-1]};
      ge_s      = (sh_s >= {1'b0, m_r});
      // when ge_s the difference is below the divisor, so DATA_W bits suffice
      diff_s    = sh_s[DATA_W-1:0] - m_r;
      div_acc_s = ge_s ? diff_s : sh_s[DATA_W-1:0];
      div_q_s   = {q_r[DATA_W-2:0], ge_s};
      quo_s     = neg_q_r ? -div_q_s : div_q_s;
      rem_s     = neg_r_r ? -div_acc_s : div_acc_s;
      acc_nx_s  = div_r ? div_acc_s : mul_acc_s;
      q_nx_s    = div_r ? div_q_s : mul_q_s;
      // x/0: remainder path ends holding |a|, re-signed back to a
      hi_res    = div_r ? rem_s : prod_fix_s[2*DATA_W-1:DATA_W];
      lo_res    = div_r ? (dbz_r ? {DATA_W{1'b1}} : quo_s) : prod_fix_s[DATA_W-1:0];
`else
      acc_nx_s  = mul_acc_s;
      q_nx_s    = mul_q_s;
      hi_res    = prod_fix_s[2*DATA_W-1:DATA_W];
      lo_res    = prod_fix_s[DATA_W-1:0];
`endif
   end

   // Operand load on start, then DATA_W iterations counted down to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r  <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
         acc_r   <= {DATA_W{1'b0}};
         q_r     <= {DATA_W{1'b0}};
         m_r     <= {DATA_W{1'b0}};
         neg_q_r <= 1'b0;
`ifdef ALU_DIV_EN
         div_r   <= 1'b0;
         dbz_r   <= 1'b0;
         neg_r_r <= 1'b0;
`endif
      end else if (start) begin
         busy_r  <= 1'b1;
         cnt_r   <= CNT_W'(DATA_W - 1);
         acc_r   <= {DATA_W{1'b0}};
         q_r     <= a_neg_s ? -a : a;
         m_r     <= b_neg_s ? -b : b;
         neg_q_r <= a_neg_s ^ b_neg_s;
`ifdef ALU_DIV_EN
         div_r   <= div;
         dbz_r   <= div && (b == {DATA_W{1'b0}});
         neg_r_r <= a_neg_s;
`endif
      end else if (busy_r) begin
         acc_r <= acc_nx_s;
         q_r   <= q_nx_s;
         if (cnt_r == {CNT_W{1'b0}}) begin
            busy_r <= 1'b0;
         end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// EX-stage execution unit: decodes alu_operation/function_code, computes
// single-cycle ops in one cycle and runs MULT/MULTU (and DIV/DIVU when
// ALU_DIV_EN is defined) through alu_muldiv_iter, updating HI/LO at the end.
// Configuration macro: ALU_DIV_EN.
// Ports:
//   clk, rst_n                clock, async active-low reset
//   in_valid / in_ready       request handshake (ready only in IDLE)
//   alu_operation, function_code, shamt, op_a, op_b   request fields
//   out_valid / out_ready     result handshake (result held until taken)
//   result, illegal           result word and undecodable/div-by-zero flag
//   hi, lo                    architectural HI/LO registers
// -----------------------------------------------------------------------------
module alu_exec_unit #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = $clog2(DATA_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         alu_operation,
   input  logic [5:0]         function_code,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [DATA_W-1:0]  op_a,
   input  logic [DATA_W-1:0]  op_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  result,
   output logic               illegal,
   output logic [DATA_W-1:0]  hi,
   output logic [DATA_W-1:0]  lo
);
   import alu_pkg::*;

   fsm_state_t        state_r;
   logic              in_ready_r;
   logic              out_valid_r;
   logic              illegal_r;
   logic [DATA_W-1:0] result_r;
   logic [DATA_W-1:0] hi_r;
   logic [DATA_W-1:0] lo_r;

   alu_dec_t          dec_s;
   logic [DATA_W-1:0] alu_res_s;
   logic              is_mul_s;
   logic              is_div_s;
   logic              is_signed_s;
   logic              start_s;
   logic              it_done_s;
   logic [DATA_W-1:0] it_hi_s;
   logic [DATA_W-1:0] it_lo_s;
`ifdef ALU_DIV_EN
   logic              it_dbz_s;
`endif

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign illegal   = illegal_r;
   assign result    = result_r;
   assign hi        = hi_r;
   assign lo        = lo_r;

   // Decode and single-cycle result from the live request fields
   always_comb begin
      dec_s = alu_decode(alu_operation, function_code);
      case (dec_s.op)
         OP_SUB:  alu_res_s = op_a - op_b;
         OP_AND:  alu_res_s = op_a & op_b;
         OP_OR:   alu_res_s = op_a | op_b;
         OP_SLT:  alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLL:  alu_res_s = op_b << shamt;
         OP_SRL:  alu_res_s = op_b >> shamt;
         OP_MFHI: alu_res_s = hi_r;
         OP_MFLO: alu_res_s = lo_r;
         default: alu_res_s = op_a + op_b;
      endcase
      is_mul_s = (dec_s.op == OP_MULT) || (dec_s.op == OP_MULTU);
`ifdef ALU_DIV_EN
      is_div_s    = (dec_s.op == OP_DIV) || (dec_s.op == OP_DIVU);
      is_signed_s = (dec_s.op == OP_MULT) || (dec_s.op == OP_DIV);
`else
      is_div_s    = 1'b0;
      is_signed_s = (dec_s.op == OP_MULT);
`endif
      start_s = (state_r == ST_IDLE) && in_valid && (is_mul_s || is_div_s);
   end

   alu_muldiv_iter #(.DATA_W(DATA_W)) u_iter (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_s),
      .is_signed (is_signed_s),
`ifdef ALU_DIV_EN
      .div       (is_div_s),
      .dbz       (it_dbz_s),
`endif
      .a         (op_a),
      .b         (op_b),
      .done      (it_done_s),
      .hi_res    (it_hi_s),
      .lo_res    (it_lo_s)
   );

   // Control FSM with registered handshake, result and HI/LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         illegal_r   <= 1'b0;
         result_r    <= {DATA_W{1'b0}};
         hi_r        <= {DATA_W{1'b0}};
         lo_r        <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  in_ready_r <= 1'b0;
                  if (is_mul_s) begin
                     state_r <= ST_MUL;
`ifdef ALU_DIV_EN
                  end else if (is_div_s) begin
                     state_r <= ST_DIV;
`endif
                  end else begin
                     result_r    <= alu_res_s;
                     illegal_r   <= dec_s.illegal;
                     out_valid_r <= 1'b1;
                     state_r     <= ST_DONE;
                  end
               end
            end
`ifdef ALU_DIV_EN
            ST_MUL, ST_DIV: begin
`else
            ST_MUL: begin
`endif
               if (it_done_s) begin
                  hi_r        <= it_hi_s;
                  lo_r        <= it_lo_s;
                  result_r    <= it_lo_s;
`ifdef ALU_DIV_EN
                  illegal_r   <= it_dbz_s;
`else
                  illegal_r   <= 1'b0;
`endif
                  out_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
               end
            end
            ST_DONE: begin
               // leaving DONE costs a cycle: no accept on this edge
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Self-checking bench for alu_exec_unit (DATA_W=32): directed vector table,
// hand-written handshake/reset sequences, and randomized operations compared
// against an arithmetic reference model. Honors ALU_DIV_EN.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  alu_operation = 3'd0;
   logic [5:0]  function_code = 6'd0;
   logic [4:0]  shamt = 5'd0;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        illegal;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_tests = 0;
   int n_fail  = 0;

   alu_exec_unit #(.DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_operation(alu_operation), .function_code(function_code),
      .shamt(shamt), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .illegal(illegal),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  aop;
      logic [5:0]  fn;
      logic [4:0]  sh;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ill;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        ill;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   vec_t vecs[$];
   logic [5:0] fn_tab [0:12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02,
                                 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] aop, input logic [5:0] fn, input logic [4:0] sh,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                               input logic ill, input logic [31:0] h, input logic [31:0] l,
                               input int lat);
      vec_t v;
      v.aop = aop; v.fn = fn; v.sh = sh; v.a = a; v.b = b;
      v.res = res; v.ill = ill; v.hi = h; v.lo = l; v.lat = lat;
      return v;
   endfunction

   // Reference model: the operation's meaning in plain arithmetic.
   function automatic exp_t model(input logic [2:0] aop, input logic [5:0] fn, input logic [4:0] sh,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] h, input logic [31:0] l);
      exp_t e;
      logic signed [63:0] sa, sb, sp;
      logic [63:0] up;
      e.res = a + b; e.ill = 1'b0; e.hi = h; e.lo = l; e.lat = 1;
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      case (aop)
         3'd1: e.res = a - b;
         3'd5: e.res = a & b;
         3'd7: e.res = a | b;
         3'd3, 3'd6: e.ill = 1'b1;
         3'd2: begin
            case (fn)
               6'h20: e.res = a + b;
               6'h22: e.res = a - b;
               6'h24: e.res = a & b;
               6'h25: e.res = a | b;
               6'h2A: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               6'h00: e.res = b << sh;
               6'h02: e.res = b >> sh;
               6'h10: e.res = h;
               6'h12: e.res = l;
               6'h18: begin
                  sp = sa * sb;
                  e.hi = sp[63:32]; e.lo = sp[31:0]; e.res = e.lo; e.lat = 33;
               end
               6'h19: begin
                  up = {32'd0, a} * {32'd0, b};
                  e.hi = up[63:32]; e.lo = up[31:0]; e.res = e.lo; e.lat = 33;
               end
`ifdef ALU_DIV_EN
               6'h1A, 6'h1B: begin
                  e.lat = 33;
                  if (b == 32'd0) begin
                     e.lo = 32'hFFFF_FFFF; e.hi = a; e.ill = 1'b1;
                  end else if (fn == 6'h1A) begin
                     sp = sa / sb; e.lo = sp[31:0];
                     sp = sa % sb; e.hi = sp[31:0];
                  end else begin
                     e.lo = a / b; e.hi = a % b;
                  end
                  e.res = e.lo;
               end
`endif
               default: e.ill = 1'b1;
            endcase
         end
         default: e.res = a + b;
      endcase
      return e;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Issue one request from IDLE, wait (bounded) for the result, then take it.
   task automatic run_op(input logic [2:0] aop, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ill, output int lat);
      @(negedge clk);
      in_valid = 1'b1; alu_operation = aop; function_code = fn; shamt = sh;
      op_a = a; op_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      alu_operation = 3'($urandom); function_code = 6'($urandom);
      shamt = 5'($urandom); op_a = $urandom; op_b = $urandom;
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
      end
      res = result; ill = illegal;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] r;
      logic        il;
      int          lt;
      int          ov_cnt;
      logic [31:0] mh, ml;
      exp_t        e;

      vecs.push_back(mk(3'd2, 6'h25, 5'd0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 32'h0, 32'h0, 1));
      vecs.push_back(mk(3'd2, 6'h18, 5'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33));
      vecs.push_back(mk(3'd2, 6'h10, 5'd0, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1));
      vecs.push_back(mk(3'd6, 6'h00, 5'd0, 32'd5, 32'd6, 32'd11, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1));
      vecs.push_back(mk(3'd2, 6'h00, 5'd31, 32'd0, 32'd1, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1));
      vecs.push_back(mk(3'd2, 6'h02, 5'd4, 32'd0, 32'h8000_0000, 32'h0800_0000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1));
      vecs.push_back(mk(3'd2, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1));
      vecs.push_back(mk(3'd2, 6'h2A, 5'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1));
      vecs.push_back(mk(3'd1, 6'h00, 5'd0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1));
      vecs.push_back(mk(3'd0, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1));
      vecs.push_back(mk(3'd2, 6'h3F, 5'd0, 32'd1, 32'd2, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1));
      vecs.push_back(mk(3'd2, 6'h12, 5'd0, 32'd1, 32'd2, 32'hFFFF_FFEB, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1));
      vecs.push_back(mk(3'd5, 6'h00, 5'd0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1));
      vecs.push_back(mk(3'd3, 6'h00, 5'd0, 32'd2, 32'd2, 32'd4, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1));
      vecs.push_back(mk(3'd4, 6'h00, 5'd0, 32'd7, 32'd8, 32'd15, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1));
      vecs.push_back(mk(3'd2, 6'h19, 5'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'hFFFF_FFFE, 33));
      vecs.push_back(mk(3'd7, 6'h00, 5'd0, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1'b0, 32'd1, 32'hFFFF_FFFE, 1));
      vecs.push_back(mk(3'd2, 6'h22, 5'd0, 32'd10, 32'd3, 32'd7, 1'b0, 32'd1, 32'hFFFF_FFFE, 1));
`ifdef ALU_DIV_EN
      vecs.push_back(mk(3'd2, 6'h1B, 5'd0, 32'd100, 32'd7, 32'd14, 1'b0, 32'd2, 32'd14, 33));
      vecs.push_back(mk(3'd2, 6'h1A, 5'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 32'd5, 32'hFFFF_FFFF, 33));
      vecs.push_back(mk(3'd2, 6'h1A, 5'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33));
`else
      vecs.push_back(mk(3'd2, 6'h1A, 5'd0, 32'd100, 32'd7, 32'd107, 1'b1, 32'd1, 32'hFFFF_FFFE, 1));
      vecs.push_back(mk(3'd2, 6'h1B, 5'd0, 32'd100, 32'd7, 32'd107, 1'b1, 32'd1, 32'hFFFF_FFFE, 1));
`endif

      // reset state while rst_n is held low
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.out_valid", {31'd0, out_valid}, 32'd0);
      check("rst.illegal", {31'd0, illegal}, 32'd0);
      check("rst.result", result, 32'd0);
      check("rst.hi", hi, 32'd0);
      check("rst.lo", lo, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst.in_ready", {31'd0, in_ready}, 32'd1);

      // directed vector table
      foreach (vecs[i]) begin
         run_op(vecs[i].aop, vecs[i].fn, vecs[i].sh, vecs[i].a, vecs[i].b, r, il, lt);
         check($sformatf("vec%0d.result", i), r, vecs[i].res);
         check($sformatf("vec%0d.illegal", i), {31'd0, il}, {31'd0, vecs[i].ill});
         check($sformatf("vec%0d.latency", i), 32'(lt), 32'(vecs[i].lat));
         check($sformatf("vec%0d.hi", i), hi, vecs[i].hi);
         check($sformatf("vec%0d.lo", i), lo, vecs[i].lo);
      end

      // back-pressure: sub 10-3 held in DONE for 5 cycles
      @(negedge clk);
      in_valid = 1'b1; alu_operation = 3'd1; op_a = 32'd10; op_b = 32'd3;
      @(posedge clk); #1;
      in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp%0d.out_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("bp%0d.result", i), result, 32'd7);
         check($sformatf("bp%0d.in_ready", i), {31'd0, in_ready}, 32'd0);
      end
      // take result with a new request already waiting: not accepted this edge
      out_ready = 1'b1; in_valid = 1'b1; alu_operation = 3'd0; op_a = 32'd1; op_b = 32'd1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("issue.gap_out_valid", {31'd0, out_valid}, 32'd0);
      check("issue.gap_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("issue.next_out_valid", {31'd0, out_valid}, 32'd1);
      check("issue.next_result", result, 32'd2);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // reset during iteration 12 of MULTU 0xFFFFFFFF x 2
      @(negedge clk);
      in_valid = 1'b1; alu_operation = 3'd2; function_code = 6'h19;
      op_a = 32'hFFFF_FFFF; op_b = 32'd2;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (12) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst.result", result, 32'd0);
      check("midrst.illegal", {31'd0, illegal}, 32'd0);
      check("midrst.hi", hi, 32'd0);
      check("midrst.lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ov_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) ov_cnt++;
      end
      check("midrst.no_out_valid", 32'(ov_cnt), 32'd0);
      check("midrst.hi_after", hi, 32'd0);
      check("midrst.lo_after", lo, 32'd0);
      check("midrst.in_ready", {31'd0, in_ready}, 32'd1);

      // randomized operations against the reference model
      mh = 32'd0; ml = 32'd0;
      for (int i = 0; i < 300; i++) begin
         logic [2:0]  aop;
         logic [5:0]  fn;
         logic [4:0]  sh;
         logic [31:0] a, b;
         int          k;
         aop = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'($urandom);
         k   = $urandom_range(0, 13);
         fn  = (k == 13) ? 6'($urandom) : fn_tab[k];
         sh  = 5'($urandom);
         a   = pick();
         b   = pick();
         e   = model(aop, fn, sh, a, b, mh, ml);
         run_op(aop, fn, sh, a, b, r, il, lt);
         check($sformatf("rnd%0d.result", i), r, e.res);
         check($sformatf("rnd%0d.illegal", i), {31'd0, il}, {31'd0, e.ill});
         check($sformatf("rnd%0d.latency", i), 32'(lt), 32'(e.lat));
         check($sformatf("rnd%0d.hi", i), hi, e.hi);
         check($sformatf("rnd%0d.lo", i), lo, e.lo);
         mh = e.hi; ml = e.lo;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
